div_unit: RTL and testbench

- Iterative RV32M divide/remainder unit for DIV, DIVU, REM and REMU.
- Multi-cycle companion to the single-cycle integer datapath. Execute stage issues a start pulse, stalls on busy, and captures the result on done.
- Restoring algorithm, one quotient bit per clock. Divide-by-zero and signed-overflow cases short-circuit to RISC-V architected results.

---
 rtl/div_unit.sv | 191 +++++++++++++++++++
 tb/tb_div_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit -- iterative RV32M divide / remainder unit (DIV, DIVU, REM, REMU).
//
// Restoring division, one quotient bit per clock. The execute stage pulses
// start, stalls while busy is high and captures div_result when done pulses.
// Divide-by-zero and signed overflow bypass the iteration and return the
// RISC-V architected results one cycle after start.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   request pulse, sampled only in IDLE or DONE
//   div_op     in   [1:0] 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   operand_a  in   [XLEN-1:0] dividend (rs1)
//   operand_b  in   [XLEN-1:0] divisor (rs2)
//   busy       out  high in RUN and FIX
//   done       out  one-cycle pulse, div_result valid
//   div_result out  [XLEN-1:0] quotient or remainder, held until next done
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, |dividend| < |divisor| skips the
//                     iteration and finishes one cycle after start.
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | XLEN restoring iterations, counter XLEN-1 down to 0
// FIX   | sign correction and quotient/remainder select
// DONE  | done pulse; accepts a new start like IDLE

module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] div_result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic            r_sel_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;

    // Operand decode for the acceptance cycle
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_early;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_accept;

    assign w_signed   = ~div_op[0];
    assign w_a_neg    = w_signed & operand_a[XLEN-1];
    assign w_b_neg    = w_signed & operand_b[XLEN-1];
    // Negating -2^(XLEN-1) yields itself, which is the correct unsigned magnitude.
    assign w_a_mag    = w_a_neg ? (~operand_a + 1'b1) : operand_a;
    assign w_b_mag    = w_b_neg ? (~operand_b + 1'b1) : operand_b;
    assign w_div_zero = (operand_b == '0);
    assign w_overflow = w_signed & (operand_a == MIN_NEG) & (operand_b == ALL_ONES);

`ifdef DIV_EARLY_OUT_EN
    assign w_early    = ~w_div_zero & ~w_overflow & (w_a_mag < w_b_mag);
`else
    assign w_early    = 1'b0;
`endif

    assign w_special  = w_div_zero | w_overflow | w_early;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = div_op[1] ? operand_a : ALL_ONES;
        end else if (w_overflow) begin
            w_special_res = div_op[1] ? '0 : MIN_NEG;
        end else if (w_early) begin
            // Quotient is zero; remainder is the untouched dividend.
            w_special_res = div_op[1] ? operand_a : '0;
        end
    end

    assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    // Restoring step: shift {rem, quo} left, trial-subtract the divisor.
    // The shifted remainder can need XLEN+1 bits; when the subtraction
    // succeeds the difference is below the divisor, so XLEN bits suffice.
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_trial;

    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_trial = w_shift[XLEN-1:0] - r_div;

    logic [XLEN-1:0] w_fix_res;

    always_comb begin
        w_fix_res = '0;
        if (r_sel_rem) begin
            w_fix_res = r_neg_r ? (~r_rem + 1'b1) : r_rem;
        end else begin
            w_fix_res = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_sel_rem <= div_op[1];
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_div     <= w_b_mag;
                        r_cnt     <= CW'(XLEN - 1);
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_RUN;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_ge) begin
                        r_rem <= w_trial;
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state == S_RUN) | (r_state == S_FIX);
    assign done       = (r_state == S_DONE);
    assign div_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed-vector bench for div_unit.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  div_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] div_result;

    int n_vec;
    int n_err;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .div_op     (div_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start (at the next falling edge unless already positioned
    // in a DONE cycle for back-to-back), then returns the cycle index of the
    // done pulse relative to the accepting edge (-1 on timeout), the number
    // of busy cycles before it, and the result seen with done.
    task automatic issue(input bit b2b, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt, output logic [31:0] res);
        if (!b2b) @(negedge clk);
        start     = 1'b1;
        div_op    = op;
        operand_a = a;
        operand_b = b;
        @(negedge clk);
        start     = 1'b0;
        div_op    = 2'b10;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h0;
        lat  = -1;
        bcnt = 0;
        res  = 32'h0;
        for (int k = 1; k <= 60; k++) begin
            if (done) begin
                lat = k;
                res = div_result;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        div_op = OP_DIVU;
        operand_a = 32'd100;
        operand_b = 32'd7;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || div_result !== 32'h0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b result=%h, want 0 0 00000000",
                     busy, done, div_result);
        end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_unsigned();
        int lat, bcnt;
        logic [31:0] res;
        issue(0, OP_DIVU, 32'd100, 32'd7, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || bcnt !== 33 || res !== 32'd14) begin
            n_err++;
            $display("FAIL divu_100_7: lat=%0d busy=%0d res=%h, want 34 33 0000000e", lat, bcnt, res);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || div_result !== 32'd14) begin
            n_err++;
            $display("FAIL hold: done=%b res=%h, want 0 0000000e", done, div_result);
        end
        issue(0, OP_REMU, 32'd100, 32'd7, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || bcnt !== 33 || res !== 32'd2) begin
            n_err++;
            $display("FAIL remu_100_7: lat=%0d busy=%0d res=%h, want 34 33 00000002", lat, bcnt, res);
        end
        issue(0, OP_DIVU, 32'hFFFF_FFFF, 32'd1, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || res !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL divu_max_1: lat=%0d res=%h, want 34 ffffffff", lat, res);
        end
        issue(0, OP_REMU, 32'hFFFF_FFFF, 32'h10, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || res !== 32'h0000_000F) begin
            n_err++;
            $display("FAIL remu_max_16: lat=%0d res=%h, want 34 0000000f", lat, res);
        end
    endtask

    task automatic test_signed();
        int lat, bcnt;
        logic [31:0] res;
        issue(0, OP_DIV, 32'hFFFF_FF9C, 32'd7, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || res !== 32'hFFFF_FFF2) begin
            n_err++;
            $display("FAIL div_m100_7: lat=%0d res=%h, want 34 fffffff2", lat, res);
        end
        issue(0, OP_REM, 32'hFFFF_FF9C, 32'd7, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || res !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL rem_m100_7: lat=%0d res=%h, want 34 fffffffe", lat, res);
        end
        issue(0, OP_REM, 32'd100, 32'hFFFF_FFF9, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || res !== 32'd2) begin
            n_err++;
            $display("FAIL rem_100_m7: lat=%0d res=%h, want 34 00000002", lat, res);
        end
        issue(0, OP_DIV, 32'd100, 32'hFFFF_FFF9, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || res !== 32'hFFFF_FFF2) begin
            n_err++;
            $display("FAIL div_100_m7: lat=%0d res=%h, want 34 fffffff2", lat, res);
        end
        issue(0, OP_DIV, 32'h8000_0000, 32'd2, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || res !== 32'hC000_0000) begin
            n_err++;
            $display("FAIL div_min_2: lat=%0d res=%h, want 34 c0000000", lat, res);
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        logic [31:0] res;
        issue(0, OP_DIVU, 32'h0000_1234, 32'h0, lat, bcnt, res);
        n_vec++;
        if (lat !== 1 || bcnt !== 0 || res !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL divu_by0: lat=%0d busy=%0d res=%h, want 1 0 ffffffff", lat, bcnt, res);
        end
        issue(0, OP_REM, 32'h8000_0005, 32'h0, lat, bcnt, res);
        n_vec++;
        if (lat !== 1 || res !== 32'h8000_0005) begin
            n_err++;
            $display("FAIL rem_by0: lat=%0d res=%h, want 1 80000005", lat, res);
        end
        issue(0, OP_DIV, 32'd5, 32'h0, lat, bcnt, res);
        n_vec++;
        if (lat !== 1 || res !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL div_by0: lat=%0d res=%h, want 1 ffffffff", lat, res);
        end
        issue(0, OP_REMU, 32'hCAFE_0001, 32'h0, lat, bcnt, res);
        n_vec++;
        if (lat !== 1 || res !== 32'hCAFE_0001) begin
            n_err++;
            $display("FAIL remu_by0: lat=%0d res=%h, want 1 cafe0001", lat, res);
        end
    endtask

    task automatic test_overflow();
        int lat, bcnt;
        logic [31:0] res;
        issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, res);
        n_vec++;
        if (lat !== 1 || bcnt !== 0 || res !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL div_ovf: lat=%0d busy=%0d res=%h, want 1 0 80000000", lat, bcnt, res);
        end
        issue(0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, res);
        n_vec++;
        if (lat !== 1 || res !== 32'h0) begin
            n_err++;
            $display("FAIL rem_ovf: lat=%0d res=%h, want 1 00000000", lat, res);
        end
    endtask

    task automatic test_busy_ignore();
        int ndone, first;
        logic [31:0] res;
        @(negedge clk);
        start = 1'b1; div_op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first = -1; res = 32'h0;
        for (int k = 1; k <= 50; k++) begin
            if (k == 5) begin
                start = 1'b1; div_op = OP_DIV; operand_a = 32'd1000; operand_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    res = div_result;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_vec++;
        if (ndone !== 1 || first !== 34 || res !== 32'd14) begin
            n_err++;
            $display("FAIL busy_ignore: pulses=%0d at=%0d res=%h, want 1 34 0000000e", ndone, first, res);
        end
    endtask

    task automatic test_reset_mid();
        int ndone, lat, bcnt;
        logic [31:0] res;
        @(negedge clk);
        start = 1'b1; div_op = OP_DIVU; operand_a = 32'hFFFF_FFFF; operand_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || div_result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b res=%h, want 0 0 00000000", busy, done, div_result);
        end
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        n_vec++;
        if (ndone !== 0) begin
            n_err++;
            $display("FAIL reset_no_done: pulses=%0d, want 0", ndone);
        end
        issue(0, OP_DIVU, 32'd50, 32'd5, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || res !== 32'd10) begin
            n_err++;
            $display("FAIL after_reset: lat=%0d res=%h, want 34 0000000a", lat, res);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        logic [31:0] res;
        issue(0, OP_DIVU, 32'd1000, 32'd10, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || res !== 32'd100) begin
            n_err++;
            $display("FAIL b2b_first: lat=%0d res=%h, want 34 00000064", lat, res);
        end
        issue(1, OP_REMU, 32'd1000, 32'd7, lat, bcnt, res);
        n_vec++;
        if (lat !== 34 || bcnt !== 33 || res !== 32'd6) begin
            n_err++;
            $display("FAIL b2b_second: lat=%0d busy=%0d res=%h, want 34 33 00000006", lat, bcnt, res);
        end
        issue(1, OP_DIVU, 32'h1234, 32'h0, lat, bcnt, res);
        n_vec++;
        if (lat !== 1 || res !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL b2b_special: lat=%0d res=%h, want 1 ffffffff", lat, res);
        end
    endtask

    task automatic test_early_out();
        int lat, bcnt, exp_lat;
        logic [31:0] res;
`ifdef DIV_EARLY_OUT_EN
        exp_lat = 1;
`else
        exp_lat = 34;
`endif
        issue(0, OP_DIVU, 32'd3, 32'd10, lat, bcnt, res);
        n_vec++;
        if (lat !== exp_lat || res !== 32'h0) begin
            n_err++;
            $display("FAIL small_divu: lat=%0d res=%h, want %0d 00000000", lat, res, exp_lat);
        end
        issue(0, OP_REM, 32'hFFFF_FFFD, 32'd10, lat, bcnt, res);
        n_vec++;
        if (lat !== exp_lat || res !== 32'hFFFF_FFFD) begin
            n_err++;
            $display("FAIL small_rem: lat=%0d res=%h, want %0d fffffffd", lat, res, exp_lat);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        div_op    = 2'b00;
        operand_a = 32'h0;
        operand_b = 32'h0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_early_out();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
